// File: rtl/serial_nibble_adder_pkg.sv
// Shared definitions for the serial nibble adder: state encoding,
// nibble width and the nibble-counter width helper.
package serial_nibble_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Width of the nibble counter: clog2(n_nibbles), never below one bit.
    function automatic int cnt_width(input int n_nibbles);
        return (n_nibbles <= 2) ? 1 : $clog2(n_nibbles);
    endfunction

endpackage

// File: rtl/serial_nibble_adder_rca4.sv
// Existing 4-bit ripple-carry adder, purely combinational.
module rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    // Ripple the carry through four full-adder stages.
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        cout = c[4];
    end

endmodule

// File: rtl/serial_nibble_adder.sv
// Wide adder built from one rca4: operands are latched on start, added one
// nibble per clock LSB first, and the result is flagged by a done pulse.
//
// Handshake: start is a request sampled only while idle (busy=0, done=0);
// the edge that sees it accepts a, b and cin. A request seen while busy or
// done is dropped, not queued. done is a single-cycle qualifier: sum, cout
// and ovf are valid in that cycle and hold until the next accepted start.
module serial_nibble_adder
    import serial_nibble_adder_pkg::*;
#(
    parameter  int N_NIBBLES = 4,
    localparam int W         = NIBBLE_W * N_NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int CW = cnt_width(N_NIBBLES);
    localparam logic [CW-1:0] LAST_CNT = CW'(N_NIBBLES - 1);

    state_t          state;
    state_t          state_next;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic            c_r;
    logic [CW-1:0]   cnt;
    logic            a_msb;
    logic            b_msb;
    logic [NIBBLE_W-1:0] nib_sum;
    logic            nib_cout;
    logic            last_nibble;

    rca4 u_rca4 (
        .a    (a_r[NIBBLE_W-1:0]),
        .b    (b_r[NIBBLE_W-1:0]),
        .cin  (c_r),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    assign last_nibble = (cnt == LAST_CNT);

    // Status flags are straight decodes of the registered state.
    assign busy = (state == ST_BUSY);
    assign done = (state == ST_DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, leave BUSY after the last nibble,
    // DONE lasts exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_BUSY;
            ST_BUSY: if (last_nibble) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: operand capture on accept, one nibble per BUSY edge, and
    // final carry/overflow captured on the edge that processes the MSB nibble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            c_r   <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                a_r   <= a;
                b_r   <= b;
                c_r   <= cin;
                cnt   <= '0;
                a_msb <= a[W-1];
                b_msb <= b[W-1];
            end else if (state == ST_BUSY) begin
                sum <= (sum >> NIBBLE_W) | (W'(nib_sum) << (W - NIBBLE_W));
                c_r <= nib_cout;
                a_r <= a_r >> NIBBLE_W;
                b_r <= b_r >> NIBBLE_W;
                cnt <= cnt + CW'(1);
                if (last_nibble) begin
                    cout <= nib_cout;
                    // The last nibble's top bit is the final sum MSB.
                    ovf  <= (a_msb == b_msb) && (nib_sum[NIBBLE_W-1] != a_msb);
                end
            end
        end
    end

endmodule

// File: doc/serial_nibble_adder.md
# serial_nibble_adder

Multi-cycle wide adder that feeds the existing 4-bit ripple-carry adder (`rca4`) one nibble per clock and collects its sum and carry outputs. Operands are latched on a start pulse, added least-significant nibble first with the carry held in a register between cycles, and the full-width sum is presented with a one-cycle done pulse. It sits directly upstream of `rca4`, which it instantiates, and presents a start/done handshake to the datapath above.

## Interface
- `N_NIBBLES`, default 4: number of nibbles per operand. Operand width is W = 4*N_NIBBLES, so 16 by default.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request. Sampled only in IDLE.
- `a` in W: operand A. Sampled on the start edge only.
- `b` in W: operand B. Sampled on the start edge only.
- `cin` in 1: carry-in to nibble 0. Sampled on the start edge.
- `busy` out 1: high while nibble additions are in progress.
- `done` out 1: one-cycle pulse when `sum`, `cout` and `ovf` become valid.
- `sum` out W: result.
- `cout` out 1: carry out of the MSB nibble.
- `ovf` out 1: signed (two's-complement) overflow.

## Operation
- State machine: IDLE, BUSY, DONE.
  - IDLE to BUSY on a clock edge with `start`=1.
  - BUSY to DONE on the edge that processes the last nibble.
  - DONE to IDLE unconditionally on the next edge.
- Accept edge (IDLE, `start`=1):
  - `a` and `b` load into shift registers A_r and B_r.
  - Carry register c_r is loaded with `cin`.
  - Nibble counter is cleared to 0.
  - MSBs `a[W-1]` and `b[W-1]` are stored for the overflow calculation.
- Each BUSY edge:
  - `rca4` adds A_r[3:0], B_r[3:0] and c_r combinationally.
  - Its 4-bit sum is shifted into `sum` from the top: sum <= {s, sum[W-1:4]}.
  - c_r <= rca4 `cout`.
  - A_r and B_r shift right by 4.
  - The counter increments. The edge where the counter equals N_NIBBLES-1 moves the state to DONE.
- Entering DONE:
  - `cout` <= final carry.
  - `ovf` <= (stored a MSB == stored b MSB) && (final `sum` MSB != stored a MSB).
- `start` is ignored in BUSY and DONE; there is no queuing.
- `sum`, `cout` and `ovf` hold their values from DONE until the next accept edge.
  - `sum` is undefined-in-progress (it shifts) while `busy`=1. Consumers sample it only on `done`.
- All arithmetic is modulo 2^W. The carry out of the MSB appears only on `cout`.

## Timing
- Reset (asynchronous, at any time, including mid-BUSY):
  - State returns to IDLE immediately.
  - `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0; counter, c_r, A_r and B_r are all 0.
  - An aborted operation produces no `done`.
  - The first rising edge after `rst` deasserts can accept `start`.
- Latency, with the accept edge called E0:
  - Nibble i is processed at edge E(1+i).
  - `busy`=1 from after E0 through edge E(N_NIBBLES).
  - `done`=1 for exactly the cycle after E(N_NIBBLES), i.e. N_NIBBLES cycles after the accept edge. This is 4 cycles at the default.
- Throughput: one operation per N_NIBBLES+2 cycles.
  - `start` held high continuously is accepted again at the edge following the DONE cycle.
- `busy` and `done` are registered, decoded from state, and never both high.

## Structure
- Shared package/include holds:
  - State encoding: IDLE=2'b00, BUSY=2'b01, DONE=2'b10.
  - NIBBLE_W=4.
  - Counter width clog2(N_NIBBLES), minimum 1.
- One sub-module: the existing `rca4`, instantiated once, purely combinational. The sequential logic (FSM, counter, shift registers, carry register) lives in this block.

## Test plan
- 0x000F + 0x000F, `cin`=0:
  - `sum`=0x001E, `cout`=0, `ovf`=0.
  - `done` is high exactly 4 cycles after the accept edge, and `busy`=1 for the 4 cycles before it.
- 0x0FFF + 0x0001, `cin`=0: `sum`=0x1000, `cout`=0. Checks carry propagation across three nibble boundaries.
- 0xFFFF + 0x0001, `cin`=0: `sum`=0x0000, `cout`=1, `ovf`=0.
- 0x7FFF + 0x0001, `cin`=0: `sum`=0x8000, `cout`=0, `ovf`=1.
- 0xFFFF + 0xFFFF, `cin`=1: `sum`=0xFFFF, `cout`=1, `ovf`=0.
  - A second `start` with new operands, pulsed during BUSY, is ignored and the result is unchanged.
- Start 0x1234 + 0x1111, then assert `rst` after the 2nd BUSY edge:
  - All outputs go to 0 immediately and no `done` pulse occurs.
  - After release, 0x1234 + 0x1111 yields `sum`=0x2345, `cout`=0.
